// File: rtl/icache.sv
// icache: direct-mapped instruction cache with in-order line fill over a word-wide memory port
module icache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 1,
  parameter int CACHE_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  IF2IC_en,
  input  logic [ADDR_WIDTH-1:0] IF2IC_addr,
  output logic                  IC2IF_en,
  output logic [31:0]           IC2IF_data,
  input  logic                  ROB2IC_pre_judge,
  output logic                  IC2MC_en,
  output logic [ADDR_WIDTH-1:0] IC2MC_addr,
  input  logic                  MC2IC_en,
  input  logic [31:0]           MC2IC_data
);
  localparam int WORDS  = 1 << BLOCK_WIDTH;
  localparam int LINES  = 1 << CACHE_WIDTH;
  localparam int TAG_LO = CACHE_WIDTH + BLOCK_WIDTH + 2;
  localparam int TAG_W  = ADDR_WIDTH - TAG_LO;
  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
  state_t state, state_nx;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [WORDS*32-1:0] data_mem [LINES];
  logic [WORDS*32-1:0] line_buf, fill_line;
  logic [BLOCK_WIDTH-1:0] fill_cnt, req_word;
  logic [CACHE_WIDTH-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic squash;
  logic [TAG_W-1:0] in_tag;
  logic [CACHE_WIDTH-1:0] in_idx;
  logic [BLOCK_WIDTH-1:0] in_word;
  logic hit, accept, mem_ack, last, kill;
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, IF2IC_addr[1:0]};
  assign in_tag  = IF2IC_addr[ADDR_WIDTH-1:TAG_LO];
  assign in_idx  = IF2IC_addr[TAG_LO-1:BLOCK_WIDTH+2];
  assign in_word = IF2IC_addr[BLOCK_WIDTH+1:2];
  assign hit     = valid[in_idx] && tag_mem[in_idx] == in_tag;
  assign accept  = rdy_in && state == IDLE && IF2IC_en && ROB2IC_pre_judge;
  assign mem_ack = rdy_in && state == FILL && MC2IC_en;
  assign last    = mem_ack && &fill_cnt;
  assign kill    = squash || !ROB2IC_pre_judge;
  assign IC2IF_en = state == RESP;
  assign IC2MC_en = state == FILL;
  // line image with the arriving memory word merged into its slot
  always_comb begin
    fill_line = line_buf;
    fill_line[{fill_cnt, 5'd0} +: 32] = MC2IC_data;
  end
  // next state: hits respond next cycle, misses fill, a squashed fill returns to idle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (hit ? RESP : FILL) : IDLE;
      FILL:    state_nx = last ? (kill ? IDLE : RESP) : FILL;
      RESP:    state_nx = rdy_in ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk_in)
    state <= rst_in ? IDLE : state_nx;
  // control registers: valid bits, memory address, response word, squash flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid      <= '0;
      IC2MC_addr <= '0;
      IC2IF_data <= '0;
      fill_cnt   <= '0;
      squash     <= 1'b0;
    end else begin
      if (accept) begin
        IC2IF_data <= data_mem[in_idx][{in_word, 5'd0} +: 32];
        fill_cnt   <= '0;
        squash     <= 1'b0;
        if (!hit) IC2MC_addr <= {in_tag, in_idx, {(BLOCK_WIDTH + 2){1'b0}}};
      end
      if (rdy_in && state == FILL && !ROB2IC_pre_judge) squash <= 1'b1;
      if (mem_ack) begin
        fill_cnt   <= fill_cnt + BLOCK_WIDTH'(1);
        IC2MC_addr <= IC2MC_addr + ADDR_WIDTH'(4);
      end
      if (last) begin
        valid[req_idx] <= 1'b1;
        IC2IF_data     <= fill_line[{req_word, 5'd0} +: 32];
      end
    end
  end
  // storage: latched request fields, fill buffer, tag and data arrays
  always_ff @(posedge clk_in) begin
    if (accept) begin
      req_tag  <= in_tag;
      req_idx  <= in_idx;
      req_word <= in_word;
    end
    if (mem_ack) line_buf <= fill_line;
    if (last) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= fill_line;
    end
  end
endmodule
